// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - bus-mapped 4-digit multiplexed 7-segment scan controller
module disp_scan_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DIV_W   = 16,
    parameter int DIV_MAX = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        Disp,
    output logic [3:0]        Disp_sel
);

    localparam logic [DIV_W-1:0] PCNT_LAST = DIV_W'(DIV_MAX - 1);
    // CTRL bit 3 is reserved and never stored
    localparam logic [7:0]       CTRL_MASK = 8'hF7;

    logic [DIV_W-1:0]  pcnt;
    logic [1:0]        dig;
    logic              tick;
    logic              commit;
    logic              wr_value;
    logic              wr_ctrl;
    logic              rd_en;

    logic [15:0]       value_sh;
    logic [7:0]        ctrl_sh;
    logic [15:0]       value_act;
    logic [7:0]        ctrl_act;
    logic              pending;
    logic              ovf;

    logic [15:0]       sh_mag;
    logic              sh_ovf;
    logic [DATA_W-1:0] rd_data;

    logic [15:0]       act_mag;
    logic [15:0]       src;
    logic [15:0]       src_shift;
    logic [3:0]        nib;
    logic [3:0]        dp_mask;
    logic              neg;
    logic              minus_dig;
    logic              blank;
    logic [6:0]        seg;
    logic [7:0]        disp_nxt;
    logic [3:0]        sel_nxt;

    logic              unused_bits;

    assign unused_bits = ^{data_in[DATA_W-1:16], ctrl_act[3]};

    assign tick     = (pcnt == PCNT_LAST);
    assign commit   = tick && (dig == 2'd3);
    assign wr_value = sel && we && (addr == 2'd0);
    assign wr_ctrl  = sel && we && (addr == 2'd1);
    assign rd_en    = sel && !we;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            default: f = 7'h0E;
        endcase
        return f;
    endfunction

    // Prescaler and digit index; free-running whether or not the display is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            dig  <= 2'd0;
        end else if (tick) begin
            pcnt <= '0;
            dig  <= dig + 2'd1;
        end else begin
            pcnt <= pcnt + DIV_W'(1);
        end
    end

    // Shadow registers take CPU writes; a write beats a same-edge commit for pending
    always_ff @(posedge clk) begin
        if (rst) begin
            value_sh <= 16'h0000;
            ctrl_sh  <= 8'h00;
            pending  <= 1'b0;
        end else begin
            if (wr_value) begin
                value_sh <= data_in[15:0];
            end
            if (wr_ctrl) begin
                ctrl_sh <= data_in[7:0] & CTRL_MASK;
            end
            if (wr_value || wr_ctrl) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Overflow flag for the shadow value, latched alongside it at commit
    always_comb begin
        sh_mag = ~value_sh + 16'd1;
        sh_ovf = ctrl_sh[1] && value_sh[15] && (sh_mag > 16'h0FFF);
    end

    // Active registers load from the pre-write shadow at the end of digit 3
    always_ff @(posedge clk) begin
        if (rst) begin
            value_act <= 16'h0000;
            ctrl_act  <= 8'h00;
            ovf       <= 1'b0;
        end else if (commit) begin
            value_act <= value_sh;
            ctrl_act  <= ctrl_sh;
            ovf       <= sh_ovf;
        end
    end

    // Read mux; VALUE and CTRL read back the shadow copies
    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data[15:0] = value_sh;
            2'd1:    rd_data[7:0]  = ctrl_sh;
            2'd2:    rd_data[3:0]  = {dig, ovf, pending};
            default: rd_data       = '0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= rd_data;
        end
    end

    // Glyph for the current digit from the active registers
    always_comb begin
        act_mag   = ~value_act + 16'd1;
        neg       = ctrl_act[1] && value_act[15];
        src       = neg ? act_mag : value_act;
        src_shift = src >> {dig, 2'b00};
        nib       = src_shift[3:0];
        dp_mask   = ctrl_act[7:4];
        minus_dig = neg && (dig == 2'd3);
        blank     = ctrl_act[2] && (dig != 2'd0) && (src_shift == 16'h0000) && !minus_dig;
        if (minus_dig) begin
            seg = 7'h3F;
        end else if (blank) begin
            seg = 7'h7F;
        end else begin
            seg = hex_font(nib);
        end
        if (ctrl_act[0]) begin
            disp_nxt = {~dp_mask[dig], seg};
            sel_nxt  = ~(4'b0001 << dig);
        end else begin
            disp_nxt = 8'hFF;
            sel_nxt  = 4'hF;
        end
    end

    // Segment and digit-enable outputs, one cycle behind dig
    always_ff @(posedge clk) begin
        if (rst) begin
            Disp     <= 8'hFF;
            Disp_sel <= 4'hF;
        end else begin
            Disp     <= disp_nxt;
            Disp_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - randomized self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

    localparam int DATA_W  = 32;
    localparam int DIV_W   = 16;
    localparam int DIV_MAX = 4;

    logic              clk;
    logic              rst;
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [7:0]        Disp;
    logic [3:0]        Disp_sel;

    int compared   = 0;
    int mismatched = 0;

    disp_scan_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] font_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: time since reset gives the digit slot directly
    int          m_n;
    logic [15:0] m_vsh, m_vact;
    logic [7:0]  m_csh, m_cact;
    logic        m_pend, m_ovf;
    logic [31:0] m_dout;
    logic [7:0]  m_disp;
    logic [3:0]  m_sel;

    function automatic logic [11:0] model_out(input int d, input logic [15:0] v, input logic [7:0] c);
        int src;
        int higher;
        logic neg;
        logic [6:0] seg;
        if (!c[0]) return 12'hFFF;
        neg    = c[1] && v[15];
        src    = neg ? 65536 - int'(v) : int'(v);
        higher = src >> (4 * d);
        if (neg && d == 3) seg = 7'h3F;
        else if (c[2] && d > 0 && higher == 0) seg = 7'h7F;
        else seg = font_tbl[higher % 16];
        return {4'hF ^ 4'(1 << d), ~c[4 + d], seg};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_n <= 0; m_vsh <= 0; m_vact <= 0; m_csh <= 0; m_cact <= 0;
            m_pend <= 0; m_ovf <= 0; m_dout <= 0; m_disp <= 8'hFF; m_sel <= 4'hF;
        end else begin
            m_n <= m_n + 1;
            {m_sel, m_disp} <= model_out((m_n / DIV_MAX) % 4, m_vact, m_cact);
            if (sel && !we) begin
                case (addr)
                    2'd0: m_dout <= {16'h0, m_vsh};
                    2'd1: m_dout <= {24'h0, m_csh};
                    2'd2: m_dout <= {28'h0, 2'((m_n / DIV_MAX) % 4), m_ovf, m_pend};
                    default: m_dout <= 32'h0;
                endcase
            end
            if ((m_n % DIV_MAX) == DIV_MAX - 1 && (m_n / DIV_MAX) % 4 == 3) begin
                m_vact <= m_vsh;
                m_cact <= m_csh;
                m_ovf  <= m_csh[1] && m_vsh[15] && (65536 - int'(m_vsh)) > 4095;
                m_pend <= 1'b0;
            end
            if (sel && we && addr == 2'd0) begin
                m_vsh  <= data_in[15:0];
                m_pend <= 1'b1;
            end
            if (sel && we && addr == 2'd1) begin
                m_csh  <= data_in[7:0] & 8'hF7;
                m_pend <= 1'b1;
            end
        end
    end

    // Bus drivers: entered and left just after a falling edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic wait_commit(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (!m_pend) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_sel_e(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (Disp_sel === 4'hE) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (Disp !== 8'hFF) begin mismatched++; $display("FAIL reset_disp: got %h want ff", Disp); end
        compared++;
        if (Disp_sel !== 4'hF) begin mismatched++; $display("FAIL reset_sel: got %h want f", Disp_sel); end
        compared++;
        if (data_out !== 32'h0) begin mismatched++; $display("FAIL reset_dout: got %h want 0", data_out); end
        rst = 1'b0;
        bus_read(2'd2);
        compared++;
        if (data_out !== 32'h0) begin mismatched++; $display("FAIL reset_status: got %h want 0", data_out); end
    endtask

    task automatic test_hex_scan;
        bit ok;
        logic [11:0] exp_tbl [4];
        exp_tbl = '{12'hE8E, 12'hD99, 12'hB88, 12'h7F9};
        repeat ($urandom_range(0, 7)) @(negedge clk);
        bus_write(2'd0, 32'hDEAD1A4F);
        bus_write(2'd1, 32'h00000001);
        bus_read(2'd2);
        compared++;
        if (data_out[0] !== 1'b1) begin mismatched++; $display("FAIL hex_pending_set: got %b want 1", data_out[0]); end
        wait_commit(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL hex_commit_timeout: got pending=1 want 0"); end
        wait_sel_e(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL hex_sel_timeout: got sel=%h want e", Disp_sel); end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if ({Disp_sel, Disp} !== exp_tbl[k / 4]) begin
                mismatched++; $display("FAIL hex_scan[%0d]: got %h want %h", k, {Disp_sel, Disp}, exp_tbl[k / 4]);
            end
            compared++;
            if ({data_out, Disp, Disp_sel} !== {m_dout, m_disp, m_sel}) begin
                mismatched++; $display("FAIL hex_model[%0d]: got %h want %h", k, {data_out, Disp, Disp_sel}, {m_dout, m_disp, m_sel});
            end
            @(negedge clk);
        end
        bus_read(2'd2);
        compared++;
        if (data_out[0] !== 1'b0) begin mismatched++; $display("FAIL hex_pending_clr: got %b want 0", data_out[0]); end
    endtask

    task automatic test_signed_blank;
        bit ok;
        logic [11:0] exp_tbl [4];
        exp_tbl = '{12'hE99, 12'hDFF, 12'hBFF, 12'h7BF};
        bus_write(2'd1, 32'h07);
        bus_write(2'd0, 32'hFFFC);
        wait_commit(ok);
        wait_sel_e(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL signed_sel_timeout: got sel=%h want e", Disp_sel); end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if ({Disp_sel, Disp} !== exp_tbl[k / 4]) begin
                mismatched++; $display("FAIL signed_scan[%0d]: got %h want %h", k, {Disp_sel, Disp}, exp_tbl[k / 4]);
            end
            @(negedge clk);
        end
        bus_read(2'd2);
        compared++;
        if (data_out[1] !== 1'b0) begin mismatched++; $display("FAIL signed_ovf: got %b want 0", data_out[1]); end
    endtask

    task automatic test_ovf;
        bit ok;
        logic [11:0] exp_tbl [4];
        exp_tbl = '{12'hEC0, 12'hDC0, 12'hBC0, 12'h7BF};
        bus_write(2'd1, 32'h03);
        bus_write(2'd0, 32'h8000);
        wait_commit(ok);
        wait_sel_e(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL ovf_sel_timeout: got sel=%h want e", Disp_sel); end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if ({Disp_sel, Disp} !== exp_tbl[k / 4]) begin
                mismatched++; $display("FAIL ovf_scan[%0d]: got %h want %h", k, {Disp_sel, Disp}, exp_tbl[k / 4]);
            end
            @(negedge clk);
        end
        bus_read(2'd2);
        compared++;
        if (data_out[1] !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b want 1", data_out[1]); end
    endtask

    task automatic test_commit_collision;
        bit ok;
        bus_write(2'd1, 32'h01);
        bus_write(2'd0, 32'h1234);
        wait_commit(ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if ((m_n % DIV_MAX) == DIV_MAX - 1 && (m_n / DIV_MAX) % 4 == 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        compared++;
        if (!ok) begin mismatched++; $display("FAIL coll_align_timeout: got no dig3 tick want one"); end
        bus_write(2'd0, 32'h5678);
        bus_read(2'd2);
        compared++;
        if (data_out[0] !== 1'b1) begin mismatched++; $display("FAIL coll_pending: got %b want 1", data_out[0]); end
        wait_sel_e(ok);
        compared++;
        if (Disp !== 8'h99) begin mismatched++; $display("FAIL coll_old_value: got %h want 99", Disp); end
        wait_commit(ok);
        wait_sel_e(ok);
        compared++;
        if (Disp !== 8'h80) begin mismatched++; $display("FAIL coll_new_value: got %h want 80", Disp); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if ((m_n / DIV_MAX) % 4 == 2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({Disp, Disp_sel} !== 12'hFFF) begin
            mismatched++; $display("FAIL midrst_out: got %h want fff", {Disp, Disp_sel});
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            compared++;
            if (Disp_sel !== 4'hF) begin mismatched++; $display("FAIL midrst_blank[%0d]: got %h want f", k, Disp_sel); end
        end
        bus_read(2'd0);
        compared++;
        if (data_out !== 32'h0) begin mismatched++; $display("FAIL midrst_value: got %h want 0", data_out); end
        bus_write(2'd1, 32'h01);
        wait_commit(ok);
        wait_sel_e(ok);
        compared++;
        if ({Disp_sel, Disp} !== 12'hEC0) begin
            mismatched++; $display("FAIL midrst_reenable: got %h want ec0", {Disp_sel, Disp});
        end
    endtask

    task automatic test_random;
        int r;
        logic [31:0] d;
        for (int k = 0; k < 800; k++) begin
            compared++;
            if ({data_out, Disp, Disp_sel} !== {m_dout, m_disp, m_sel}) begin
                mismatched++;
                $display("FAIL random[%0d]: got %h want %h", k, {data_out, Disp, Disp_sel}, {m_dout, m_disp, m_sel});
            end
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = $urandom_range(0, 300);
                2: d = 32'h0000FFFF - $urandom_range(0, 300);
                default: d = {$urandom, 1'b1} & 32'hFF | 32'h1;
            endcase
            sel = (r < 6);
            we = (r < 3);
            addr = 2'($urandom_range(0, 3));
            data_in = d;
            @(negedge clk);
        end
        rst = 1'b0; sel = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        @(negedge clk);
        test_reset;
        test_hex_scan;
        test_signed_blank;
        test_ovf;
        test_commit_collision;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Memory-mapped peripheral on the picoVersat data bus. It drives the 4-digit multiplexed 7-segment display of the calculator: a prescaler time-shares the segment bus across the four digits, and a decoder turns a 16-bit value into hex, signed or blanked glyphs. CPU writes go to shadow registers. They are committed to the active registers only at a frame boundary, so the display never tears mid-scan. It replaces the ad-hoc Disp/Disp_sel logic in xtop.

Parameters:
DATA_W, 32, CPU data bus width
DIV_W, 16, prescaler counter width
DIV_MAX, 50000, clk cycles per digit slot (must be >= 2 and < 2**DIV_W)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
sel  in  1  peripheral select
we  in  1  write enable, qualified by sel
addr  in  2  register address
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data, registered
Disp  out  8  segments, active-low: [6:0]=gfedcba, [7]=dp
Disp_sel  out  4  digit enables, active-low one-hot; [0]=rightmost digit

Behaviour:
- Register map:
  - addr 0 VALUE: bits [15:0] are written; upper bits are ignored.
  - addr 1 CTRL: [0] en, [1] signed, [2] lzb (leading-zero blank), [7:4] dp mask, one bit per digit.
  - addr 2 STATUS, read-only: [0] pending, [1] ovf, [3:2] current digit index.
  - addr 3 reads 0. Writes to addr 2 and addr 3 are ignored.
- Write: when sel&we, VALUE or CTRL shadow updates at the clock edge and pending is set to 1.
- Read: when sel&~we, data_out takes the addressed register (shadow for VALUE and CTRL) at the next edge. Otherwise data_out holds its value.
- Prescaler: pcnt counts 0..DIV_MAX-1 and wraps. tick = (pcnt==DIV_MAX-1). It runs regardless of en.
- Digit index dig, 2 bits: increments on tick and wraps 3->0.
- Commit: on a tick with dig==3, the active VALUE/CTRL registers are loaded from shadow and pending clears.
  - If a write occurs on the same edge as a commit, the commit uses the pre-write shadow and pending stays 1.
  - Enabling or disabling therefore takes effect only at a frame boundary.
- Outputs Disp and Disp_sel are registered from dig and the active registers. They lag dig by 1 cycle.
- Glyph decode for digit d, from active registers:
  - en=0: Disp=8'hFF, Disp_sel=4'hF.
  - Unsigned mode: nibble = value[4d+3:4d].
  - Signed mode with value[15]=1: mag = (~value+1)[15:0]. Digits 0..2 show mag nibbles and digit 3 shows '-' (7'h3F, Disp[6:0]). ovf=1 if mag>12'hFFF, otherwise ovf=0. ovf is recomputed on each commit.
  - Signed mode with value[15]=0: same as unsigned.
  - lzb=1: digit d in 1..3 is blanked (7'h7F) when its nibble and all higher nibbles are 0. A '-' is never blanked. Digit 0 is never blanked.
  - dp: Disp[7] = ~dpmask[d].
- Hex font (Disp[6:0], active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset: clears pcnt, dig, all shadow and active registers, pending and ovf. Outputs become data_out=0, Disp=8'hFF, Disp_sel=4'hF. Reset mid-scan aborts the frame; the scan restarts at digit 0 after DIV_MAX cycles.
- All state is in the clk domain. There are no combinational paths from bus inputs to Disp or Disp_sel.

Test Plan:
1. Reset held for 2 cycles, then released -> Disp=8'hFF, Disp_sel=4'hF, data_out=0, STATUS reads 0.
2. With DIV_MAX=4: write VALUE=16'h1A4F and CTRL=8'h01 at arbitrary phase, then read STATUS immediately -> pending=1. After the next dig 3->0 tick, pending=0 and the display cycles:
   - Disp_sel=E with Disp=8E
   - Disp_sel=D with Disp=99
   - Disp_sel=B with Disp=88
   - Disp_sel=7 with Disp=F9
   - each for 4 cycles.
3. CTRL=8'h07, VALUE=16'hFFFC -> digits 0..3 show 99 (4), FF (blank), FF (blank), BF (-). ovf=0.
4. CTRL=8'h03, VALUE=16'h8000 -> ovf=1. Digits 0..2 show C0 and digit 3 shows BF.
5. Write VALUE on the exact edge of a dig==3 tick -> the old value is committed and pending stays 1. The new value appears after the next frame boundary.
6. Assert rst mid-frame while dig=2 -> on the next edge Disp=8'hFF, Disp_sel=4'hF, and the active registers are cleared. Display stays blank until CTRL is rewritten and committed.
